// File: rtl/usr_shift_ctrl_pkg.sv
// Shared encodings for the USR command sequencer: command opcodes, USR select
// codes and controller states.
package usr_ctrl_pkg;

  localparam int OP_W  = 2;
  localparam int SEL_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'd0;
  localparam logic [OP_W-1:0] OP_SHR  = 2'd1;
  localparam logic [OP_W-1:0] OP_SHL  = 2'd2;
  localparam logic [OP_W-1:0] OP_XFER = 2'd3;

  localparam logic [SEL_W-1:0] SEL_HOLD  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_RIGHT = 2'd1;
  localparam logic [SEL_W-1:0] SEL_LEFT  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_LOAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/usr_shift_ctrl_if.sv
// Command handshake bundle for usr_shift_ctrl; cmd_rotate exists only when
// USR_SHIFT_CTRL_ROTATE_EN is defined.
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  import usr_ctrl_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
  logic             cmd_rotate;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_rotate, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_count, cmd_rotate, output cmd_ready);
`else
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_count, output cmd_ready);
`endif

endinterface

// File: rtl/usr_shift_ctrl.sv
// Command sequencer driving a 4-bit universal shift register cycle by cycle.
// Optional rotate mode (recirculate the outgoing bit) via USR_SHIFT_CTRL_ROTATE_EN.
module usr_shift_ctrl
  import usr_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  usr_shift_ctrl_if.slave   cmd,
  input  logic              ser_in,
  output logic              ser_out,
  output logic              ser_out_valid,
  input  logic [WIDTH-1:0]  usr_pout,
  output logic [SEL_W-1:0]  usr_select,
  output logic [WIDTH-1:0]  usr_pin,
  output logic              usr_right_s_in,
  output logic              usr_left_s_in,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_XFER = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q;
  logic             rot_s;
  logic             right_s;

`ifdef USR_SHIFT_CTRL_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_s = rot_q;
`else
  assign rot_s = 1'b0;
`endif

  // run_q keeps cmd_ready low until the first edge after reset is released
  assign cmd.cmd_ready = (state_q == ST_IDLE) && run_q;
  assign right_s       = (op_q != OP_SHL);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);

  // State and command-latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      run_q   <= 1'b1;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Next-state and command latching
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid && cmd.cmd_ready) begin
          op_d   = cmd.cmd_op;
          data_d = cmd.cmd_data;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
          rot_d  = cmd.cmd_rotate;
`endif
          case (cmd.cmd_op)
            OP_LOAD: begin
              count_d = '0;
              state_d = ST_LOAD;
            end
            OP_XFER: begin
              count_d = CNT_XFER;
              state_d = ST_LOAD;
            end
            default: begin
              count_d = cmd.cmd_count;
              if (cmd.cmd_count == '0) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_SHIFT;
              end
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (op_q == OP_XFER) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // USR drive: pin must recirculate pout while shifting since the USR shifts its pin
  always_comb begin
    usr_select     = SEL_HOLD;
    usr_pin        = '0;
    ser_out        = 1'b0;
    ser_out_valid  = 1'b0;
    usr_right_s_in = 1'b0;
    usr_left_s_in  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        usr_select = SEL_LOAD;
        usr_pin    = data_q;
      end
      ST_SHIFT: begin
        usr_pin       = usr_pout;
        ser_out_valid = 1'b1;
        if (right_s) begin
          usr_select     = SEL_RIGHT;
          ser_out        = usr_pout[0];
          usr_right_s_in = rot_s ? usr_pout[0] : ser_in;
        end else begin
          usr_select     = SEL_LEFT;
          ser_out        = usr_pout[WIDTH-1];
          usr_left_s_in  = rot_s ? usr_pout[WIDTH-1] : ser_in;
        end
      end
      default: begin
        usr_select = SEL_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed self-checking bench for usr_shift_ctrl driving a behavioural 4-bit USR.
// Rotate steps run only when USR_SHIFT_CTRL_ROTATE_EN is defined.
module tb_usr_shift_ctrl;
  import usr_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       ser_in;
  logic       ser_out;
  logic       ser_out_valid;
  logic [3:0] usr_pout;
  logic [1:0] usr_select;
  logic [3:0] usr_pin;
  logic       usr_right_s_in;
  logic       usr_left_s_in;
  logic       busy;
  logic       done;
  logic [3:0] usr_q = 4'b0000;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  usr_shift_ctrl_if #(.WIDTH(4), .CNT_W(3)) cif ();

  usr_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (cif),
    .ser_in         (ser_in),
    .ser_out        (ser_out),
    .ser_out_valid  (ser_out_valid),
    .usr_pout       (usr_pout),
    .usr_select     (usr_select),
    .usr_pin        (usr_pin),
    .usr_right_s_in (usr_right_s_in),
    .usr_left_s_in  (usr_left_s_in),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register (no reset: it keeps its value)
  always @(posedge clk) begin
    case (usr_select)
      2'd1:    usr_q <= {usr_right_s_in, usr_pin[3:1]};
      2'd2:    usr_q <= {usr_pin[2:0], usr_left_s_in};
      2'd3:    usr_q <= usr_pin;
      default: usr_q <= usr_q;
    endcase
  end
  assign usr_pout = usr_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    cif.cmd_count = cnt;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    ser_in        = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_data  = 4'd0;
    cif.cmd_count = 3'd0;
`ifdef USR_SHIFT_CTRL_ROTATE_EN
    cif.cmd_rotate = 1'b0;
`endif

    // reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", usr_select, 2'd0);
    chk("rst_pin", usr_pin, 4'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_sov", ser_out_valid, 1'b0);
    chk("rst_ready", cif.cmd_ready, 1'b0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", cif.cmd_ready, 1'b1);

    // LOAD 1011: LOAD cycle, DONE at accept+2
    issue(OP_LOAD, 4'b1011, 3'd0);
    chk("ld_sel", usr_select, 2'd3);
    chk("ld_pin", usr_pin, 4'b1011);
    chk("ld_busy", busy, 1'b1);
    chk("ld_ready", cif.cmd_ready, 1'b0);
    chk("ld_nodone", done, 1'b0);
    tick();
    chk("ld_done", done, 1'b1);
    chk("ld_pout", usr_pout, 4'b1011);
    chk("ld_done_sel", usr_select, 2'd0);
    tick();
    chk("ld_idle_done", done, 1'b0);
    chk("ld_idle_ready", cif.cmd_ready, 1'b1);

    // SHR 2 with ser_in=1 from 1011
    ser_in = 1'b1;
    issue(OP_SHR, 4'b0000, 3'd2);
    chk("shr_sel", usr_select, 2'd1);
    chk("shr_pin", usr_pin, 4'b1011);
    chk("shr_sov0", ser_out_valid, 1'b1);
    chk("shr_so0", ser_out, 1'b1);
    chk("shr_rsi", usr_right_s_in, 1'b1);
    chk("shr_lsi", usr_left_s_in, 1'b0);
    tick();
    chk("shr_so1", ser_out, 1'b1);
    chk("shr_mid_pout", usr_pout, 4'b1101);
    chk("shr_mid_done", done, 1'b0);
    tick();
    chk("shr_done", done, 1'b1);
    chk("shr_pout", usr_pout, 4'b1110);
    chk("shr_done_sov", ser_out_valid, 1'b0);
    tick();

    // SHL 3 with ser_in=0 from 1011
    issue(OP_LOAD, 4'b1011, 3'd0);
    tick();
    tick();
    ser_in = 1'b0;
    issue(OP_SHL, 4'b0000, 3'd3);
    chk("shl_sel", usr_select, 2'd2);
    chk("shl_so0", ser_out, 1'b1);
    chk("shl_rsi", usr_right_s_in, 1'b0);
    tick();
    chk("shl_so1", ser_out, 1'b0);
    tick();
    chk("shl_so2", ser_out, 1'b1);
    chk("shl_mid_done", done, 1'b0);
    tick();
    chk("shl_done", done, 1'b1);
    chk("shl_pout", usr_pout, 4'b1000);
    tick();

    // XFER 0110: stream 0,1,1,0 then DONE at accept+6
    issue(OP_XFER, 4'b0110, 3'd0);
    chk("xf_ld_sel", usr_select, 2'd3);
    chk("xf_ld_sov", ser_out_valid, 1'b0);
    tick();
    chk("xf_sov0", ser_out_valid, 1'b1);
    chk("xf_so0", ser_out, 1'b0);
    tick();
    chk("xf_sov1", ser_out_valid, 1'b1);
    chk("xf_so1", ser_out, 1'b1);
    tick();
    chk("xf_sov2", ser_out_valid, 1'b1);
    chk("xf_so2", ser_out, 1'b1);
    tick();
    chk("xf_sov3", ser_out_valid, 1'b1);
    chk("xf_so3", ser_out, 1'b0);
    chk("xf_mid_done", done, 1'b0);
    tick();
    chk("xf_done", done, 1'b1);
    chk("xf_sov_end", ser_out_valid, 1'b0);
    chk("xf_pout", usr_pout, 4'b0000);
    tick();

    // SHR 6 (count beyond width) with ser_in=1 from 0000
    ser_in = 1'b1;
    issue(OP_SHR, 4'b0000, 3'd6);
    for (int i = 0; i < 6; i++) begin
      chk("shr6_sov", ser_out_valid, 1'b1);
      chk("shr6_nodone", done, 1'b0);
      tick();
    end
    chk("shr6_done", done, 1'b1);
    chk("shr6_pout", usr_pout, 4'b1111);
    tick();

    // SHR 0: DONE next cycle; a held command waits for IDLE
    ser_in = 1'b0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_SHR;
    cif.cmd_count = 3'd0;
    tick();
    chk("z_done", done, 1'b1);
    chk("z_sel", usr_select, 2'd0);
    chk("z_sov", ser_out_valid, 1'b0);
    cif.cmd_op   = OP_LOAD;
    cif.cmd_data = 4'b0101;
    chk("z_busy_ready", cif.cmd_ready, 1'b0);
    tick();
    chk("z_idle_done", done, 1'b0);
    chk("z_idle_busy", busy, 1'b0);
    chk("z_idle_ready", cif.cmd_ready, 1'b1);
    chk("z_pout_kept", usr_pout, 4'b1111);
    tick();
    cif.cmd_valid = 1'b0;
    chk("z_next_sel", usr_select, 2'd3);
    tick();
    chk("z_next_done", done, 1'b1);
    chk("z_next_pout", usr_pout, 4'b0101);
    tick();

    // Reset in the middle of SHR 5 from 0101
    ser_in = 1'b1;
    issue(OP_SHR, 4'b0000, 3'd5);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_sel", usr_select, 2'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_sov", ser_out_valid, 1'b0);
    tick();
    tick();
    chk("mid_rst_done2", done, 1'b0);
    chk("mid_rst_pout", usr_pout, 4'b1010);
    #3;
    reset = 1'b1;
    tick();
    chk("mid_rel_ready", cif.cmd_ready, 1'b1);
    chk("mid_rel_done", done, 1'b0);
    chk("mid_rel_busy", busy, 1'b0);

`ifdef USR_SHIFT_CTRL_ROTATE_EN
    // Rotate SHR 4 on 1001 restores the word
    ser_in = 1'b0;
    issue(OP_LOAD, 4'b1001, 3'd0);
    tick();
    tick();
    cif.cmd_rotate = 1'b1;
    issue(OP_SHR, 4'b0000, 3'd4);
    cif.cmd_rotate = 1'b0;
    chk("rot_so0", ser_out, 1'b1);
    chk("rot_rsi0", usr_right_s_in, 1'b1);
    tick();
    chk("rot_so1", ser_out, 1'b0);
    tick();
    tick();
    chk("rot_so3", ser_out, 1'b1);
    tick();
    chk("rot_done", done, 1'b1);
    chk("rot_pout", usr_pout, 4'b1001);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
